// File: rtl/vend_change_sequencer.sv
// Change-return sequencer for the vending machine coin hopper.
// Pays out an amount given in nickel units one coin at a time, choosing the
// largest coin that still fits and is in stock (quarter, then dime, then
// nickel). Each eject request is held until the hopper acknowledges it or a
// timeout expires. Inventory, remaining amount and the short/jam flags are
// visible to the vending FSM.
module vend_change_sequencer #(
  parameter int INV_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       amt,
  input  logic             load_inv,
  input  logic [INV_W-1:0] inv_q_in,
  input  logic [INV_W-1:0] inv_d_in,
  input  logic [INV_W-1:0] inv_n_in,
  input  logic             hop_ack,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic             jam,
  output logic [5:0]       remaining,
  output logic [INV_W-1:0] inv_q,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_n
);

  // Coin slot indices used throughout: 0 = quarter, 1 = dime, 2 = nickel.
  localparam int NUM_COINS = 3;

  // Last value of the stall counter before a jam is declared. The eject is
  // therefore high for exactly TIMEOUT cycles when no ack ever arrives.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

  // Coin denomination in nickel units for a given slot index.
  function automatic logic [5:0] coin_value(input logic [1:0] idx);
    case (idx)
      2'd0:    return 6'd5;
      2'd1:    return 6'd2;
      default: return 6'd1;
    endcase
  endfunction

  state_t           state_reg, state_next;
  logic [5:0]       remaining_reg, remaining_next;
  logic             short_reg, short_next;
  logic             jam_reg, jam_next;
  logic [1:0]       sel_reg, sel_next;
  logic [7:0]       tmo_reg, tmo_next;

  logic [INV_W-1:0] inv_reg [NUM_COINS];
  logic [INV_W-1:0] inv_in  [NUM_COINS];
  logic             load_en;
  logic [2:0]       dec_en;
  logic [2:0]       qual;

  assign inv_in[0] = inv_q_in;
  assign inv_in[1] = inv_d_in;
  assign inv_in[2] = inv_n_in;

  // A coin qualifies when it does not overshoot the amount still owed and
  // at least one is left in its tube.
  generate
    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_qual
      assign qual[gi] = (remaining_reg >= coin_value(2'(gi))) &&
                        (inv_reg[gi] != '0);
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      short_reg     <= 1'b0;
      jam_reg       <= 1'b0;
      sel_reg       <= 2'd0;
      tmo_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      short_reg     <= short_next;
      jam_reg       <= jam_next;
      sel_reg       <= sel_next;
      tmo_reg       <= tmo_next;
    end
  end

  // Coin tube counters: bulk load while idle, decrement on an acked eject.
  // The non-zero guard keeps a counter from wrapping even though the coin
  // selection already guarantees stock.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_COINS; i++) begin
      if (rst) begin
        inv_reg[i] <= '0;
      end else if (load_en) begin
        inv_reg[i] <= inv_in[i];
      end else if (dec_en[i] && (inv_reg[i] != '0)) begin
        inv_reg[i] <= inv_reg[i] - INV_W'(1);
      end
    end
  end

  // Next-state logic: greedy coin choice, eject handshake and stall timeout.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    short_next     = short_reg;
    jam_next       = jam_reg;
    sel_next       = sel_reg;
    tmo_next       = tmo_reg;
    load_en        = 1'b0;
    dec_en         = 3'b000;

    case (state_reg)
      S_IDLE: begin
        // An inventory load takes priority over a simultaneous start.
        if (load_inv) begin
          load_en = 1'b1;
        end else if (start) begin
          remaining_next = amt;
          short_next     = 1'b0;
          jam_next       = 1'b0;
          tmo_next       = '0;
          state_next     = S_PICK;
        end
      end

      S_PICK: begin
        tmo_next = '0;
        if (remaining_reg == 6'd0) begin
          state_next = S_DONE;
        end else if (qual[0]) begin
          sel_next   = 2'd0;
          state_next = S_REQ;
        end else if (qual[1]) begin
          sel_next   = 2'd1;
          state_next = S_REQ;
        end else if (qual[2]) begin
          sel_next   = 2'd2;
          state_next = S_REQ;
        end else begin
          // Nothing in stock fits the remainder; no backtracking is tried.
          short_next = 1'b1;
          state_next = S_FAULT;
        end
      end

      S_REQ: begin
        if (hop_ack) begin
          remaining_next  = remaining_reg - coin_value(sel_reg);
          dec_en[sel_reg] = 1'b1;
          tmo_next        = '0;
          state_next      = S_PICK;
        end else if (tmo_reg == TMO_LAST) begin
          jam_next   = 1'b1;
          tmo_next   = '0;
          state_next = S_FAULT;
        end else begin
          tmo_next = tmo_reg + 8'd1;
        end
      end

      S_DONE, S_FAULT: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded directly from the registered state.
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE) || (state_reg == S_FAULT);
  assign eject_q   = (state_reg == S_REQ) && (sel_reg == 2'd0);
  assign eject_d   = (state_reg == S_REQ) && (sel_reg == 2'd1);
  assign eject_n   = (state_reg == S_REQ) && (sel_reg == 2'd2);
  assign short     = short_reg;
  assign jam       = jam_reg;
  assign remaining = remaining_reg;
  assign inv_q     = inv_reg[0];
  assign inv_d     = inv_reg[1];
  assign inv_n     = inv_reg[2];

endmodule
